// File: rtl/mul_if.sv
// Handshake and data bundle for the sequential 32x32 unsigned multiplier.
// The requester drives start/a/b; the multiplier returns busy/done/product.
interface mul_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/mul_block.sv
// Radix-2 shift-add unsigned multiplier: 32 steps per operation, with
// back-to-back starts accepted from DONE and a registered 64-bit product.
module mul_block (
    input  logic  clk,
    input  logic  rst,
    mul_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] mcand_r;
    logic [31:0] mplier_r;
    logic [31:0] acc_hi_r;
    logic [4:0]  count_r;
    logic        busy_r;
    logic        done_r;
    logic [63:0] product_r;

    logic [32:0] sum_s;
    logic [31:0] acc_next_s;
    logic [31:0] mplier_next_s;

    // One shift-add step; the 65-bit right shift of {sum, mplier} keeps the carry in acc_hi[31]
    always_comb begin
        sum_s = {1'b0, acc_hi_r};
        if (mplier_r[0]) begin
            sum_s = {1'b0, acc_hi_r} + {1'b0, mcand_r};
        end else begin
            sum_s = {1'b0, acc_hi_r};
        end
        {acc_next_s, mplier_next_s} = {sum_s, mplier_r[31:1]};
    end

    // Control FSM and datapath registers; outputs are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            mcand_r   <= 32'd0;
            mplier_r  <= 32'd0;
            acc_hi_r  <= 32'd0;
            count_r   <= 5'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= 64'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        mcand_r  <= bus.a;
                        mplier_r <= bus.b;
                        acc_hi_r <= 32'd0;
                        count_r  <= 5'd0;
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi_r <= acc_next_s;
                    mplier_r <= mplier_next_s;
                    count_r  <= count_r + 5'd1;
                    if (count_r == 5'd31) begin
                        product_r <= {acc_next_s, mplier_next_s};
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        mcand_r  <= bus.a;
                        mplier_r <= bus.b;
                        acc_hi_r <= 32'd0;
                        count_r  <= 5'd0;
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;

endmodule

// File: tb/tb_mul_block.sv
// Directed self-checking bench for mul_block: reset, products, ignored
// start during RUN, back-to-back operation and reset abort.
module tb_mul_block;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    mul_if bus_if ();

    mul_block u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge; optionally leave start high.
    task automatic launch(input logic [31:0] av, input logic [31:0] bv, input bit keep);
        bus_if.start = 1'b1;
        bus_if.a     = av;
        bus_if.b     = bv;
        tick();
        if (!keep) bus_if.start = 1'b0;
    endtask

    // Step until done (bounded), checking busy/done/product-hold before it and latency/result at it.
    task automatic finish_op(input string tag, input logic [63:0] exp,
                             input logic [63:0] prev, input int already);
        int  n;
        bit  seen;
        int  bad;
        n    = already;
        seen = 1'b0;
        bad  = 0;
        check({tag, "_busy_after_accept"}, {63'd0, bus_if.busy}, 64'd1);
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            n++;
            if (bus_if.done === 1'b1) begin
                seen = 1'b1;
            end else if (bus_if.busy !== 1'b1 || bus_if.product !== prev) begin
                bad++;
            end
        end
        check({tag, "_run_window"}, 64'(bad), 64'd0);
        check({tag, "_latency"}, 64'(n), 64'd32);
        check({tag, "_done"}, {63'd0, bus_if.done}, 64'd1);
        check({tag, "_busy_in_done"}, {63'd0, bus_if.busy}, 64'd0);
        check({tag, "_product"}, bus_if.product, exp);
    endtask

    initial begin
        int bad;
        n_checks      = 0;
        n_fails       = 0;
        rst           = 1'b1;
        bus_if.start  = 1'b1;
        bus_if.a      = 32'hFFFF_FFFF;
        bus_if.b      = 32'hFFFF_FFFF;
        tick();
        tick();
        check("reset_busy", {63'd0, bus_if.busy}, 64'd0);
        check("reset_done", {63'd0, bus_if.done}, 64'd0);
        check("reset_product", bus_if.product, 64'd0);

        // Start on the first edge with rst low.
        rst = 1'b0;
        launch(32'd3, 32'd5, 1'b0);
        finish_op("mul_3x5", 64'h0000_0000_0000_000F, 64'd0, 0);
        tick();
        check("done_one_cycle", {63'd0, bus_if.done}, 64'd0);
        tick();
        tick();
        check("idle_product_hold", bus_if.product, 64'h0000_0000_0000_000F);

        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        finish_op("mul_max", 64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_000F, 0);
        tick();

        launch(32'h1234_5678, 32'd0, 1'b0);
        finish_op("mul_b_zero", 64'd0, 64'hFFFF_FFFE_0000_0001, 0);
        tick();

        launch(32'd0, 32'h9ABC_DEF0, 1'b0);
        finish_op("mul_a_zero", 64'd0, 64'd0, 0);
        tick();

        launch(32'h8000_0000, 32'h8000_0000, 1'b0);
        finish_op("mul_msb", 64'h4000_0000_0000_0000, 64'd0, 0);
        tick();

        // Start and operand changes during RUN must be ignored.
        launch(32'd2, 32'd7, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        bus_if.start = 1'b1;
        bus_if.a     = 32'hFFFF_FFFF;
        bus_if.b     = 32'hFFFF_FFFF;
        tick();
        bus_if.start = 1'b0;
        check("ignored_start_busy", {63'd0, bus_if.busy}, 64'd1);
        finish_op("mul_ignore", 64'h0000_0000_0000_000E, 64'h4000_0000_0000_0000, 10);
        tick();

        // Back-to-back: start held throughout, new operands presented in DONE.
        launch(32'd6, 32'd7, 1'b1);
        finish_op("b2b_first", 64'h0000_0000_0000_002A, 64'h0000_0000_0000_000E, 0);
        bus_if.a = 32'h8000_0000;
        bus_if.b = 32'd2;
        tick();
        bus_if.start = 1'b0;
        check("b2b_no_bubble_done", {63'd0, bus_if.done}, 64'd0);
        finish_op("b2b_second", 64'h0000_0001_0000_0000, 64'h0000_0000_0000_002A, 0);
        tick();

        // Reset aborting a run: no done, product cleared, then a clean restart.
        launch(32'h0001_0000, 32'h0001_0000, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {63'd0, bus_if.busy}, 64'd0);
        check("abort_done", {63'd0, bus_if.done}, 64'd0);
        check("abort_product", bus_if.product, 64'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) bad++;
        end
        check("abort_quiet", 64'(bad), 64'd0);
        launch(32'h0001_0000, 32'h0001_0000, 1'b0);
        finish_op("after_abort", 64'h0000_0001_0000_0000, 64'd0, 0);
        tick();
        check("final_idle_done", {63'd0, bus_if.done}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mul_block.md
MUL_BLOCK -- requirements
Module: mul_block

Interface
REQ-001 Parameter: none; all widths are fixed (32-bit operands, 64-bit product).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE or DONE.
REQ-005 a  input  32  multiplicand, unsigned; sampled on the accepted start edge only.
REQ-006 b  input  32  multiplier, unsigned; sampled on the accepted start edge only.
REQ-007 busy  output  1  high while an operation is iterating.
REQ-008 done  output  1  single-cycle pulse marking a valid new product.
REQ-009 product  output  64  unsigned a*b of the most recent completed operation.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE; reset state SHALL be IDLE.
REQ-011 IDLE: start=1 at an edge -> latch a into mcand, b into mplier, acc_hi=0, count=0; next state RUN.
REQ-012 IDLE: start=0 -> remain IDLE; internal registers and product unchanged.
REQ-013 RUN: each edge performs one shift-add step: if mplier[0]=1, sum = {1'b0,acc_hi} + {1'b0,mcand} (33-bit, carry-in 0), else sum = {1'b0,acc_hi}.
REQ-014 RUN step: {acc_hi, mplier} <= {sum, mplier} >> 1 (65-bit right shift); bit 32 of sum (carry-out) SHALL enter acc_hi[31]; no carry SHALL be lost.
REQ-015 RUN: count SHALL increment each step; on the step where count=31, state -> DONE and product <= final {acc_hi, mplier}.
REQ-016 Latency: start accepted at edge E -> 32 steps at edges E+1..E+32 -> done=1 in the cycle after edge E+32.
REQ-017 busy SHALL be 1 exactly in RUN (32 cycles per operation), 0 in IDLE and DONE.
REQ-018 done SHALL be 1 exactly in DONE, for one cycle; DONE -> IDLE at the next edge if start=0.
REQ-019 DONE with start=1 -> accept new operands as in REQ-011 and go directly to RUN (back-to-back, no idle bubble).
REQ-020 start while RUN SHALL be ignored; a and b changes during RUN SHALL NOT affect the result.
REQ-021 product SHALL hold its last value through IDLE and RUN; it SHALL update only on the RUN->DONE edge.
REQ-022 Result SHALL be exact for all operand pairs; max product 0xFFFFFFFE_00000001 fits 64 bits without overflow.
REQ-023 Operand zero SHALL NOT shorten the operation; latency is always 32 steps.

Reset
REQ-024 rst=1 at an edge -> state IDLE, busy=0, done=0, product=0, acc_hi=0, mplier=0, mcand=0, count=0.
REQ-025 rst SHALL take priority over start and over any in-progress RUN; an aborted operation SHALL NOT assert done or update product.
REQ-026 After rst deasserts, a start on the first edge with rst=0 SHALL be accepted.

Verification
REQ-027 a=3, b=5, start pulsed at edge E -> busy=1 for 32 cycles, done=1 only in the cycle after edge E+32, product=0x0000_0000_0000_000F.
REQ-028 a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE_00000001 (exercises carry-out every step).
REQ-029 a=0x12345678, b=0 and a=0, b=0x9ABCDEF0 -> product=0 after a full 32-step latency each.
REQ-030 Start a=2, b=7; at step 10 drive start=1, a=0xFFFFFFFF, b=0xFFFFFFFF -> ignored; product=0xE at done.
REQ-031 Start a=0x10000, b=0x10000; assert rst at step 16 -> busy=0, done never pulses, product=0; new start afterwards completes normally.
REQ-032 Hold start=1 with a=6, b=7 then a=0x80000000, b=2 in the DONE cycle -> done pulses twice 33 cycles apart, products 0x2A then 0x1_0000_0000.
